register_file: RTL and testbench
================================

# register_file

Architectural integer register file for the single-issue RV32I processor; it sits directly upstream of the ALU and supplies its two source operands. It holds 32 registers of 32 bits, with two combinational read ports and one synchronous write port. Register x0 is hard-wired to zero. A write-through bypass lets a value written this cycle appear on a read port in the same cycle. Register x2 (sp) loads a configurable initial value on reset.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH registers
- SP_INIT, 32'h0000_1000, value loaded into x2 on reset
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  synchronous reset, active-high
- RF_WE_i  input  1  write enable
- RF_RD_ADDR_i  input  ADDR_WIDTH  index of the register to write
- RF_RD_DATA_i  input  DATA_WIDTH  data to write
- RF_RS1_ADDR_i  input  ADDR_WIDTH  read port 1 index
- RF_RS2_ADDR_i  input  ADDR_WIDTH  read port 2 index
- RF_RS1_DATA_o  output  DATA_WIDTH  read port 1 data; drives the ALU RS1 operand
- RF_RS2_DATA_o  output  DATA_WIDTH  read port 2 data; drives the ALU RS2 operand, either directly or through the immediate mux

## Operation
- Reset: when rst=1 at a rising clk edge, every register becomes 0, except x2, which becomes SP_INIT.
  - rst has priority over any write in the same cycle; that write is dropped.
- Write: when rst=0 and RF_WE_i=1 at a rising edge, register[RF_RD_ADDR_i] takes RF_RD_DATA_i.
  - A write to x0 is ignored; x0 always reads 0.
  - The write is full-word only; there is no byte masking.
- Read: each port is purely combinational from its address and the current state.
  - Address 0 returns 0 regardless of stored content or bypass.
  - Bypass: if RF_WE_i=1, rst=0, the port address equals RF_RD_ADDR_i, and the address is non-zero, the port returns RF_RD_DATA_i instead of the stored value.
  - Both ports may read the same register, and both may bypass at the same time.
- Storage has no parity and no X-propagation. Every register has a defined value after the first reset.
- Unused upper address values cannot occur, because the address width covers the whole array.

## Timing
- Read latency is 0 cycles: outputs settle combinationally within the same cycle.
- Write latency is 1 edge: the stored value is visible without bypass from the cycle after the write.
- Bypass makes a write visible in the same cycle as the write. A read-after-write on consecutive instructions therefore needs no stall.
- Outputs during and after reset:
  - In the cycle rst is asserted: outputs reflect the stored contents (bypass is suppressed).
  - From the cycle after: x0=0, x2=SP_INIT, all other registers 0.
- Reset asserted mid-program: a pending write in that cycle is lost, and all state clears on that edge.
- Back-to-back writes to the same register: the last write wins. Each intermediate value is visible via bypass only in its own cycle.
- Simultaneous write and read of the same address: the read returns the new data (bypass), and storage holds the new data after the edge.

## Structure
- Shared package (riscv_pkg) holds:
  - XLEN=32 and REG_ADDR_W=5
  - Architectural indices REG_ZERO=0, REG_RA=1, REG_SP=2
  - The default SP_INIT constant
- Storage is a reg array [0:2**ADDR_WIDTH-1] with a single always block for reset and write.
- Each read port is one combinational assign with zero check, bypass, then array read.
- Sub-module: a per-port read mux, rf_read_port, instantiated twice, holding the zero-check, bypass and array-read logic.

## Test plan
- Reset: assert rst for 1 cycle, then read all 32 addresses -> x2=32'h0000_1000, every other register 0.
- Write then read: write x5=32'hDEAD_BEEF; next cycle, RS1=5 -> 32'hDEAD_BEEF. RS2=6 -> 0.
- x0 protection: WE=1, RD=0, data 32'hFFFF_FFFF; same cycle and next cycle, RS1=0 -> 0.
- Bypass: in the same cycle as writing x7=32'h1234_5678, with RS1=RS2=7 -> both ports 32'h1234_5678 before the edge. Storage holds it after the edge.
- Reset priority: rst=1 together with WE=1, RD=9, data 32'hA5A5_A5A5 -> x9 reads 0 after the edge, and RS1=9 returns the old value during the reset cycle.
- Back-to-back: write x3=1, then x3=2 on consecutive cycles, with RS1=3 throughout -> reads 1, then 2, then 2.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I constants: base word/index widths, architectural register
// indices and the default initial stack pointer.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 1;
    localparam int REG_SP   = 2;

    localparam logic [XLEN-1:0] SP_INIT_DEFAULT = 32'h0000_1000;

endpackage

// File: rtl/register_file_if.sv
// Register-file access bundle: one write port and two read ports.
// The master side is the issuing stage; the slave side is the register file.
interface register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);

    logic                  RF_WE_i;
    logic [ADDR_WIDTH-1:0] RF_RD_ADDR_i;
    logic [DATA_WIDTH-1:0] RF_RD_DATA_i;
    logic [ADDR_WIDTH-1:0] RF_RS1_ADDR_i;
    logic [ADDR_WIDTH-1:0] RF_RS2_ADDR_i;
    logic [DATA_WIDTH-1:0] RF_RS1_DATA_o;
    logic [DATA_WIDTH-1:0] RF_RS2_DATA_o;

    modport master (
        output RF_WE_i, RF_RD_ADDR_i, RF_RD_DATA_i, RF_RS1_ADDR_i, RF_RS2_ADDR_i,
        input  RF_RS1_DATA_o, RF_RS2_DATA_o
    );

    modport slave (
        input  RF_WE_i, RF_RD_ADDR_i, RF_RD_DATA_i, RF_RS1_ADDR_i, RF_RS2_ADDR_i,
        output RF_RS1_DATA_o, RF_RS2_DATA_o
    );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: x0 forces zero, a same-cycle write to the
// addressed register is forwarded, otherwise the stored word is returned.
module rf_read_port
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic                  bypass_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [DATA_WIDTH-1:0] regs [0:(2**ADDR_WIDTH)-1],
    output logic [DATA_WIDTH-1:0] rs_data
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    // Zero check outranks the bypass so a write aimed at x0 can never leak out.
    assign rs_data = (rs_addr == ZERO_ADDR)                 ? '0      :
                     (bypass_en && (rs_addr == rd_addr))    ? rd_data :
                                                              regs[rs_addr];

endmodule

// File: rtl/register_file.sv
// RV32I architectural register file: 32 x 32-bit, two combinational read
// ports with write-through bypass, one synchronous write port, x2 reset to SP_INIT.
module register_file
    import riscv_pkg::*;
#(
    parameter int                    DATA_WIDTH = XLEN,
    parameter int                    ADDR_WIDTH = REG_ADDR_W,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = SP_INIT_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    register_file_if.slave rf
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [0:DEPTH-1];
    logic                  bypass_en;

    // Forwarding is suppressed while reset is held, since that write is dropped.
    assign bypass_en = rf.RF_WE_i & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (i == REG_SP) ? SP_INIT : '0;
            end
        end else if (rf.RF_WE_i && (rf.RF_RD_ADDR_i != '0)) begin
            regs[rf.RF_RD_ADDR_i] <= rf.RF_RD_DATA_i;
        end
    end

    rf_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rs1_port (
        .rs_addr   (rf.RF_RS1_ADDR_i),
        .bypass_en (bypass_en),
        .rd_addr   (rf.RF_RD_ADDR_i),
        .rd_data   (rf.RF_RD_DATA_i),
        .regs      (regs),
        .rs_data   (rf.RF_RS1_DATA_o)
    );

    rf_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rs2_port (
        .rs_addr   (rf.RF_RS2_ADDR_i),
        .bypass_en (bypass_en),
        .rd_addr   (rf.RF_RD_ADDR_i),
        .rd_data   (rf.RF_RD_DATA_i),
        .regs      (regs),
        .rs_data   (rf.RF_RS2_DATA_o)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: each stimulus cycle queues its expected
// read-port values, and a negedge monitor pops and compares them.
module tb_register_file;

    localparam logic [31:0] SP_VAL = 32'h0000_1000;

    typedef struct {
        string       name;
        logic        chk1;
        logic        chk2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } expect_t;

    logic clk;
    logic rst;

    int checks_done = 0;
    int fail_count  = 0;

    expect_t exp_q[$];

    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf_bus ();

    register_file dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs just after the rising edge and queues what the
    // read ports must show before the next edge.
    task automatic apply_stimulus(
        input string       name,
        input logic        rst_v,
        input logic        we,
        input logic [4:0]  rd,
        input logic [31:0] wdata,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic        chk1,
        input logic [31:0] exp1,
        input logic        chk2,
        input logic [31:0] exp2
    );
        expect_t e;
        @(posedge clk);
        #1;
        rst                  = rst_v;
        rf_bus.RF_WE_i       = we;
        rf_bus.RF_RD_ADDR_i  = rd;
        rf_bus.RF_RD_DATA_i  = wdata;
        rf_bus.RF_RS1_ADDR_i = rs1;
        rf_bus.RF_RS2_ADDR_i = rs2;
        e.name = name;
        e.chk1 = chk1;
        e.chk2 = chk2;
        e.exp1 = exp1;
        e.exp2 = exp2;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks_done++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: compares the settled outputs mid-cycle against the queued entry.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            expect_t e;
            e = exp_q.pop_front();
            if (e.chk1) check_output({e.name, "/rs1"}, rf_bus.RF_RS1_DATA_o, e.exp1);
            if (e.chk2) check_output({e.name, "/rs2"}, rf_bus.RF_RS2_DATA_o, e.exp2);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst                  = 1'b1;
        rf_bus.RF_WE_i       = 1'b0;
        rf_bus.RF_RD_ADDR_i  = '0;
        rf_bus.RF_RD_DATA_i  = '0;
        rf_bus.RF_RS1_ADDR_i = '0;
        rf_bus.RF_RS2_ADDR_i = '0;

        // Initial reset: stored contents are undefined during it, so nothing is checked.
        apply_stimulus("reset", 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Reset values across all 32 registers, two per cycle.
        for (int k = 0; k < 16; k++) begin
            logic [4:0]  a1;
            logic [4:0]  a2;
            logic [31:0] e1;
            logic [31:0] e2;
            a1 = 5'(2 * k);
            a2 = 5'(2 * k + 1);
            e1 = (a1 == 5'd2) ? SP_VAL : 32'h0;
            e2 = (a2 == 5'd2) ? SP_VAL : 32'h0;
            apply_stimulus("reset_value", 1'b0, 1'b0, 5'd0, 32'h0, a1, a2, 1'b1, e1, 1'b1, e2);
        end

        apply_stimulus("write_x5",     1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd6, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0);
        apply_stimulus("read_x5",      1'b0, 1'b0, 5'd0, 32'h0,         5'd5, 5'd6, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0);

        apply_stimulus("write_x0",     1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, 32'h0, 1'b1, 32'h0);
        apply_stimulus("read_x0",      1'b0, 1'b0, 5'd0, 32'h0,         5'd0, 5'd5, 1'b1, 32'h0, 1'b1, 32'hDEAD_BEEF);

        apply_stimulus("bypass_x7",    1'b0, 1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678);
        apply_stimulus("stored_x7",    1'b0, 1'b0, 5'd0, 32'h0,         5'd7, 5'd7, 1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678);

        apply_stimulus("write_sp",     1'b0, 1'b1, 5'd2, 32'h0000_2000, 5'd2, 5'd5, 1'b1, 32'h0000_2000, 1'b1, 32'hDEAD_BEEF);
        apply_stimulus("write_x9",     1'b0, 1'b1, 5'd9, 32'h1111_1111, 5'd9, 5'd2, 1'b1, 32'h1111_1111, 1'b1, 32'h0000_2000);

        // Reset with a competing write: outputs show old contents, write is dropped.
        apply_stimulus("rst_prio",     1'b1, 1'b1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd2, 1'b1, 32'h1111_1111, 1'b1, 32'h0000_2000);
        apply_stimulus("after_rst",    1'b0, 1'b0, 5'd0, 32'h0,         5'd9, 5'd7, 1'b1, 32'h0, 1'b1, 32'h0);
        apply_stimulus("after_rst_sp", 1'b0, 1'b0, 5'd0, 32'h0,         5'd2, 5'd5, 1'b1, SP_VAL, 1'b1, 32'h0);

        apply_stimulus("b2b_first",    1'b0, 1'b1, 5'd3, 32'h0000_0001, 5'd3, 5'd4, 1'b1, 32'h1, 1'b1, 32'h0);
        apply_stimulus("b2b_second",   1'b0, 1'b1, 5'd3, 32'h0000_0002, 5'd3, 5'd3, 1'b1, 32'h2, 1'b1, 32'h2);
        apply_stimulus("b2b_stored",   1'b0, 1'b0, 5'd0, 32'h0,         5'd3, 5'd3, 1'b1, 32'h2, 1'b1, 32'h2);

        apply_stimulus("bypass_x31",   1'b0, 1'b1, 5'd31, 32'hCAFE_F00D, 5'd3, 5'd31, 1'b1, 32'h2, 1'b1, 32'hCAFE_F00D);
        apply_stimulus("stored_x31",   1'b0, 1'b0, 5'd0,  32'h0,         5'd31, 5'd30, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h0);

        @(posedge clk);
        @(posedge clk);
        rf_bus.RF_WE_i = 1'b0;

        if (exp_q.size() != 0) begin
            fail_count++;
            $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fail_count);
        $finish;
    end

endmodule
